muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit sitting directly downstream of the register file: consumes
//  read_data1/read_data2 as rs1_data/rs2_data and returns a 32-bit result to the writeback mux.
//  Takes multiple cycles per operation, so it drives a stall that freezes PC and regfile write
//  until the result is ready. Covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
// PARAMETERS
//  XLEN     `INSTRUCTION_SIZE (32)    operand/result width
//  CNT_W    $clog2(XLEN)+1 (6)        iteration counter width
// PORTS
//  clk       in   1     single clock, rising edge
//  rst       in   1     synchronous, active-high reset
//  start     in   1     M-extension instruction present; level, held until done
//  funct3    in   3     RV32M op: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1_data  in   XLEN  operand A (regfile read_data1)
//  rs2_data  in   XLEN  operand B (regfile read_data2)
//  stall     out  1     combinational: start & ~done; gates PC update and regwrite
//  busy      out  1     registered: operation in flight
//  done      out  1     registered one-cycle pulse: result valid
//  result    out  XLEN  registered result; held until next accepted start
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, busy=0, done=0, result=0, counter=0, all operand regs 0.
//    Reset mid-operation aborts it; nothing is written; next start is accepted normally.
//  - FSM states: IDLE, CALC, FIXUP, DONE.
//    IDLE  : start=1 -> latch funct3, |rs1|,|rs2|, result sign; special case -> DONE, else -> CALC.
//    CALC  : one radix-2 step per cycle (shift-add multiply / restoring divide); counter 0..31;
//            after step 31 -> FIXUP.
//    FIXUP : two's-complement negate if result sign set; select hi/lo word -> result; -> DONE.
//    DONE  : done=1, busy=0; always -> IDLE; start ignored (same instruction retiring).
//  - Latency: start high in cycle 0 (IDLE) -> busy high cycles 1..33 -> done=1 in cycle 34.
//    Special case: done=1 in cycle 1, busy stays 0.
//  - Operands and funct3 are sampled only on the accepting edge; later changes are ignored.
//  - Signedness: MUL/MULH/DIV/REM signed x signed; MULHSU rs1 signed, rs2 unsigned;
//    MULHU/DIVU/REMU unsigned. Multiply uses a 64-bit product register: MUL returns [31:0],
//    MULH* return [63:32]. Quotient sign = sA^sB; remainder sign = sA.
//  - Special cases (fast path, no CALC):
//    divisor==0    : DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1_data.
//    DIV overflow  : rs1=0x80000000, rs2=0xFFFFFFFF -> DIV 0x80000000, REM 0x00000000.
//  - Back-to-back: DONE returns to IDLE at the next edge; a start in the cycle after done
//    is a new instruction and is accepted.
//  - stall is low in the done cycle, so the datapath retires the instruction and writes
//    result through the normal regfile write port (rd==x0 discard is the regfile's job).
// STRUCTURE
//  - RISCV_PKG.vh gains: `MULDIV_FUNCT3_* encodings (8 defines), `OPCODE_OP funct7 value
//    0000001 as `FUNCT7_MULDIV, `MULDIV_ITER (32), FSM state encodings.
//  - One combinational sub-module is natural: muldiv_step (single shift-add / restoring-subtract
//    step on {hi,lo,divisor}, selected by is_div); FSM, counter, sign fixup stay in muldiv_unit.
// TESTING
//  1. MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; busy cycles 1..33, done only in cycle 34.
//  2. MULH 0x80000000x0x80000000 -> 0x40000000; MULHU 0xFFFFFFFFx0xFFFFFFFF -> 0xFFFFFFFE;
//     MULHSU 0xFFFFFFFFx0xFFFFFFFF -> 0xFFFFFFFF.
//  3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//  4. DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000,
//     REM same -> 0; each with done in cycle 1, busy never high.
//  5. rst=1 in cycle 10 of a MUL -> next cycle busy=0, done=0, result=0; new start then
//     gives the correct result in 34 cycles.
//  6. Operands toggled during busy -> result unchanged; start held through done -> exactly
//     one done pulse; second start in cycle 35 accepted, done in cycle 69.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and op-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned CNT_W       = $clog2(XLEN) + 1;
  localparam int unsigned MULDIV_ITER = 32;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCalc  = 2'd1;
  localparam logic [1:0] StFixup = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [XLEN-1:0] XlenMinInt = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic op_a_signed(input logic [2:0] f3);
    return f3 inside {F3Mul, F3Mulh, F3Mulhsu, F3Div, F3Rem};
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return f3 inside {F3Mul, F3Mulh, F3Div, F3Rem};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on {hi, lo}.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;

  always_comb begin
    sum    = {1'b0, hi_i} + {1'b0, divisor_i};
    rem_sh = {hi_i, lo_i[XLEN-1]};
    // Only used when rem_sh >= divisor, so the result always fits in XLEN bits.
    diff   = rem_sh[XLEN-1:0] - divisor_i;
    if (is_div_i) begin
      if (rem_sh >= {1'b0, divisor_i}) begin
        hi_o = diff;
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        hi_o = rem_sh[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end
    end else if (lo_i[0]) begin
      {hi_o, lo_o} = {sum, lo_i[XLEN-1:1]};
    end else begin
      {hi_o, lo_o} = {1'b0, hi_i, lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: magnitudes are processed unsigned over 32 steps, then sign-fixed.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   div_q, div_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, done_q;

  logic [XLEN-1:0]   step_hi, step_lo;
  logic              a_neg, b_neg, is_div, div_zero, div_ovf;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_word;

  muldiv_step u_step (
    .is_div_i  (f3_q[2]),
    .hi_i      (hi_q),
    .lo_i      (lo_q),
    .divisor_i (div_q),
    .hi_o      (step_hi),
    .lo_o      (step_lo)
  );

  always_comb begin
    a_neg    = op_a_signed(funct3_i) & rs1_data_i[XLEN-1];
    b_neg    = op_b_signed(funct3_i) & rs2_data_i[XLEN-1];
    a_abs    = a_neg ? -rs1_data_i : rs1_data_i;
    b_abs    = b_neg ? -rs2_data_i : rs2_data_i;
    is_div   = funct3_i[2];
    div_zero = is_div && (rs2_data_i == '0);
    div_ovf  = ((funct3_i == F3Div) || (funct3_i == F3Rem)) &&
               (rs1_data_i == XlenMinInt) && (rs2_data_i == '1);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_d    = div_q;
    result_d = result_q;
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    div_word = f3_q[1] ? hi_q : lo_q;
    if (neg_q) div_word = -div_word;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          f3_d  = funct3_i;
          // Remainder takes the dividend's sign; everything else takes sA^sB.
          neg_d = (is_div && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = is_div ? a_abs : b_abs;
          div_d = is_div ? b_abs : a_abs;
          if (div_zero) begin
            state_d  = StDone;
            result_d = funct3_i[1] ? rs1_data_i : '1;
          end else if (div_ovf) begin
            state_d  = StDone;
            result_d = funct3_i[1] ? '0 : rs1_data_i;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == CNT_W'(MULDIV_ITER - 1)) begin
          cnt_d   = '0;
          state_d = StFixup;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFixup: begin
        state_d = StDone;
        if (f3_q[2])             result_d = div_word;
        else if (f3_q == F3Mul)  result_d = prod_fix[XLEN-1:0];
        else                     result_d = prod_fix[2*XLEN-1:XLEN];
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      div_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div_q    <= div_d;
      result_q <= result_d;
      busy_q   <= (state_d == StCalc) || (state_d == StFixup);
      done_q   <= (state_d == StDone);
    end
  end

  assign stall_o  = start_i & ~done_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized ops vs a 64-bit model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        stall, busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .funct3_i   (funct3),
    .rs1_data_i (rs1),
    .rs2_data_i (rs2),
    .stall_o    (stall),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (f3[2] && b == 0) ||
           ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Entered #1 after a clock edge (cycle 0); leaves #1 after the edge following done.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit toggle);
    int cyc      = 0;
    int exp_done = is_fast(f3, a, b) ? 1 : 34;
    bit seen     = 0;
    start  = 1'b1;
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    #1;
    check_eq({tag, " stall_c0"}, 32'(stall), 32'd1);
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      check_eq({tag, " busy"}, 32'(busy), 32'(exp_done == 34 && cyc >= 1 && cyc <= 33));
      check_eq({tag, " done"}, 32'(done), 32'(cyc == exp_done));
      if (done) begin
        seen = 1;
        check_eq({tag, " result"}, result, exp);
        check_eq({tag, " stall_done"}, 32'(stall), 32'd0);
      end
      if (toggle) begin
        rs1    = $urandom;
        rs2    = $urandom;
        funct3 = 3'($urandom);
      end
    end
    if (!seen) check_eq({tag, " timeout"}, 32'd0, 32'd1);
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [7] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'h2, 32'h7};
    if ($urandom_range(3) == 0) return corners[$urandom_range(6)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] a, b;
    logic [2:0]  f3;
    int          n_done;

    rst    = 1'b1;
    start  = 1'b0;
    funct3 = '0;
    rs1    = '0;
    rs2    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset result", result, 32'd0);
    check_eq("reset stall", 32'(stall), 32'd0);
    rst = 1'b0;

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 0);
    run_op("div0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("remu0", 3'd7, 32'd5, 32'd0, 32'd5, 0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    run_op("mul_tog", 3'd0, 32'h1234_5678, 32'h9ABC_DEF1,
           ref_model(3'd0, 32'h1234_5678, 32'h9ABC_DEF1), 1);

    // Reset in cycle 10 of a MUL aborts it.
    start  = 1'b1;
    funct3 = 3'd0;
    rs1    = 32'd3;
    rs2    = 32'd5;
    repeat (10) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort done", 32'(done), 32'd0);
    check_eq("abort result", result, 32'd0);
    rst = 1'b0;
    run_op("post_rst", 3'd0, 32'd3, 32'd5, 32'd15, 0);

    // Start held through done: one pulse at 34, next op accepted in 35, done at 69.
    start  = 1'b1;
    funct3 = 3'd3;
    rs1    = 32'hDEAD_BEEF;
    rs2    = 32'hCAFE_F00D;
    n_done = 0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
      check_eq("hold done", 32'(done), 32'(c == 34 || c == 69));
      if (c == 34) check_eq("hold res1", result, ref_model(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D));
      if (c == 69) begin
        check_eq("hold res2", result, ref_model(3'd5, 32'hDEAD_BEEF, 32'd13));
        start = 1'b0;
      end
      if (c < 34 || (c >= 36 && c < 69)) begin
        rs1    = $urandom;
        rs2    = $urandom;
        funct3 = 3'($urandom);
      end else if (c == 34) begin
        funct3 = 3'd5;
        rs1    = 32'hDEAD_BEEF;
        rs2    = 32'd13;
      end
    end
    check_eq("hold n_done", 32'(n_done), 32'd2);

    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      run_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, ref_model(f3, a, b), i[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
